huffman_sym_encoder: RTL
========================

Name: huffman_sym_encoder

Overview:
Transmit-side counterpart of the Huffman code detector. It holds a runtime-configurable symbol-to-code table (data value -> Huffman code + length) and accepts data symbols over a valid/ready handshake. Each symbol is serialized as its Huffman code, MSB-first, one bit per beat on a valid/ready bit stream. It sits between the data source and the compressed-stream packer in the Huffman encoder path.

Parameters:
D_W, 4, symbol (data) width; table depth = 2**D_W
C_W, 4, maximum Huffman code width
L_W, 3, code-length field width; must satisfy 2**L_W > C_W

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
d_conf  in  D_W  config: symbol (table index) to write
h_conf  in  C_W  config: code, right-aligned
l_conf  in  L_W  config: code length in bits
en_conf  in  1  config write strobe
new_conf  in  1  clear all table entries
s_valid  in  1  symbol valid
s_ready  out  1  symbol ready
s_data  in  D_W  symbol
b_valid  out  1  code bit valid
b_ready  in  1  downstream ready
b_bit  out  1  current code bit
b_last  out  1  marks the final bit of the current code
sym_err  out  1  one-cycle pulse: accepted symbol has no valid entry

Behaviour:
- Table: per entry code[C_W], len[L_W], vld flag.
  - On en_conf: entry[d_conf] <= {h_conf, l_conf}; vld = (l_conf != 0 && l_conf <= C_W).
  - On new_conf: all vld <= 0.
  - new_conf and en_conf in the same cycle: new_conf wins; the write is dropped.
- Reset (rst low, async):
  - state=IDLE, all vld=0.
  - b_valid=0, b_bit=0, b_last=0, sym_err=0.
  - Shift register and counter are cleared.
  - s_ready=1 once rst is released.
- FSM states: IDLE, SHIFT.
- s_ready = (state==IDLE) & ~en_conf & ~new_conf. This is combinational, so no symbol is accepted in a config cycle.
- IDLE, on accept (s_valid & s_ready) in cycle N, the table is read combinationally at s_data:
  - If vld: load shreg <= code, cnt <= len, then go to SHIFT.
    - b_valid=1 from N+1.
    - b_bit = shreg[cnt-1].
    - b_last = (cnt==1).
  - If not vld: sym_err=1 in N+1 only. Stay in IDLE; no bits are emitted.
- SHIFT, on a beat (b_valid & b_ready):
  - cnt <= cnt-1 and the next bit is presented.
  - If cnt==1: b_valid <= 0, go to IDLE. s_ready is high the following cycle.
- Backpressure: while b_ready=0, b_valid, b_bit and b_last are held stable.
- Throughput: a code of length L takes L beats plus 1 IDLE bubble cycle.
- Table writes during SHIFT are allowed. The in-flight code is latched, so writes affect only later symbols.
- Length-1 codes: a single beat with b_last=1.
- Reset mid-SHIFT: the in-flight code is discarded and b_valid drops immediately.
- All outputs except s_ready are registered.

Decomposition:
- Package huffman_pkg holds:
  - D_W/C_W/L_W defaults
  - IDLE/SHIFT state encoding
  - the entry record layout (code, len, vld)
- Sub-module huffman_code_table:
  - table storage plus clear/write logic
  - one combinational read port
  - same en_conf/new_conf interface and priority as the decoder-side configuration
- The FSM and serializer stay in huffman_sym_encoder.

Test Plan:
- Reset: hold rst=0 -> b_valid=0, sym_err=0. Release -> s_ready=1. Symbol 0 sent with no config -> sym_err pulse, no b_valid.
- Config sym 3 = code 4'b0101, len 3; send 3 with b_ready=1 -> b_bit 1,0,1 on cycles N+1..N+3, b_last only on N+3, s_ready=1 at N+4.
- Same code with b_ready=0 for 2 cycles after the first beat -> second bit (0) held stable with b_valid=1 for 3 cycles. Stream remains 1,0,1.
- en_conf and new_conf together (sym 5, len 2) -> entry not written. Sending 5 -> sym_err pulse. s_ready=0 during that config cycle.
- Config sym 1 = len 1 code 1 while sym 3 is in SHIFT, rewriting sym 3 to len 2 -> in-flight stream unchanged. Next 3 emits 2 bits. Symbol 1 emits one beat with b_last=1.
- Assert rst mid-SHIFT -> b_valid=0 asynchronously. After release, previously configured symbol 3 gives sym_err because the table was cleared.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman symbol encoder: default widths,
// serializer FSM state encoding and the code-table entry record layout.
package huffman_pkg;

  localparam int HUFF_D_W = 4;
  localparam int HUFF_C_W = 4;
  localparam int HUFF_L_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } enc_state_t;

  // One table entry: right-aligned code, its length in bits, and whether
  // the entry currently holds a usable code.
  typedef struct packed {
    logic [HUFF_C_W-1:0] code;
    logic [HUFF_L_W-1:0] len;
    logic                vld;
  } huff_entry_t;

endpackage

// File: rtl/huffman_code_table.sv
// Runtime-configurable symbol-to-code table with one combinational read port.
// A table clear always beats a simultaneous entry write.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int D_W = HUFF_D_W,
  parameter int C_W = HUFF_C_W,
  parameter int L_W = HUFF_L_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] i_dConf,
  input  logic [C_W-1:0] i_hConf,
  input  logic [L_W-1:0] i_lConf,
  input  logic           i_enConf,
  input  logic           i_newConf,
  input  logic [D_W-1:0] i_rdAddr,
  output logic [C_W-1:0] o_rdCode,
  output logic [L_W-1:0] o_rdLen,
  output logic           o_rdVld
);

  localparam int DEPTH = 2**D_W;

  logic [C_W-1:0] r_code [DEPTH];
  logic [L_W-1:0] r_len  [DEPTH];
  logic           r_vld  [DEPTH];

  logic w_lenOk;

  assign w_lenOk = (i_lConf != '0) && (i_lConf <= L_W'(C_W));

  // Storage update: reset or clear invalidates every entry; a write marks the entry valid only for a usable length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_code[i] <= '0;
        r_len[i]  <= '0;
        r_vld[i]  <= 1'b0;
      end
    end else if (i_newConf) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else if (i_enConf) begin
      r_code[i_dConf] <= i_hConf;
      r_len[i_dConf]  <= i_lConf;
      r_vld[i_dConf]  <= w_lenOk;
    end
  end

  assign o_rdCode = r_code[i_rdAddr];
  assign o_rdLen  = r_len[i_rdAddr];
  assign o_rdVld  = r_vld[i_rdAddr];

endmodule

// File: rtl/huffman_sym_encoder.sv
// Huffman symbol encoder: looks up each accepted symbol in the code table and
// serializes its code MSB-first, one bit per valid/ready beat.
module huffman_sym_encoder
  import huffman_pkg::*;
#(
  parameter int D_W = HUFF_D_W,
  parameter int C_W = HUFF_C_W,
  parameter int L_W = HUFF_L_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] d_conf,
  input  logic [C_W-1:0] h_conf,
  input  logic [L_W-1:0] l_conf,
  input  logic           en_conf,
  input  logic           new_conf,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [D_W-1:0] s_data,
  output logic           b_valid,
  input  logic           b_ready,
  output logic           b_bit,
  output logic           b_last,
  output logic           sym_err
);

  enc_state_t     r_state;
  logic [C_W-1:0] r_shreg;
  logic [L_W-1:0] r_cnt;
  logic           r_bValid;
  logic           r_bBit;
  logic           r_bLast;
  logic           r_symErr;

  enc_state_t     w_stateNext;
  logic [C_W-1:0] w_shregNext;
  logic [L_W-1:0] w_cntNext;
  logic           w_bValidNext;
  logic           w_bBitNext;
  logic           w_bLastNext;
  logic           w_symErrNext;

  logic [C_W-1:0] w_rdCode;
  logic [L_W-1:0] w_rdLen;
  logic           w_rdVld;
  logic [C_W-1:0] w_aligned;
  logic           w_accept;

  huffman_code_table #(
    .D_W(D_W),
    .C_W(C_W),
    .L_W(L_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .i_dConf  (d_conf),
    .i_hConf  (h_conf),
    .i_lConf  (l_conf),
    .i_enConf (en_conf),
    .i_newConf(new_conf),
    .i_rdAddr (s_data),
    .o_rdCode (w_rdCode),
    .o_rdLen  (w_rdLen),
    .o_rdVld  (w_rdVld)
  );

  // The shift register keeps the code MSB-aligned so the presented bit is
  // always the top bit; a valid entry guarantees len <= C_W.
  assign w_aligned = w_rdCode << (L_W'(C_W) - w_rdLen);

  assign s_ready  = (r_state == IDLE) & ~en_conf & ~new_conf;
  assign w_accept = s_valid & s_ready;

  // Next-state logic: load a looked-up code on accept, then advance one bit per beat.
  always_comb begin
    w_stateNext  = r_state;
    w_shregNext  = r_shreg;
    w_cntNext    = r_cnt;
    w_bValidNext = r_bValid;
    w_bBitNext   = r_bBit;
    w_bLastNext  = r_bLast;
    w_symErrNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_rdVld) begin
            w_stateNext  = SHIFT;
            w_shregNext  = w_aligned;
            w_cntNext    = w_rdLen;
            w_bValidNext = 1'b1;
            w_bBitNext   = w_aligned[C_W-1];
            w_bLastNext  = (w_rdLen == L_W'(1));
          end else begin
            w_symErrNext = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_bValid && b_ready) begin
          w_cntNext = r_cnt - L_W'(1);
          if (r_cnt == L_W'(1)) begin
            w_stateNext  = IDLE;
            w_shregNext  = '0;
            w_bValidNext = 1'b0;
            w_bBitNext   = 1'b0;
            w_bLastNext  = 1'b0;
          end else begin
            w_shregNext = r_shreg << 1;
            w_bBitNext  = w_shregNext[C_W-1];
            w_bLastNext = (r_cnt == L_W'(2));
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight code immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_bValid <= 1'b0;
      r_bBit   <= 1'b0;
      r_bLast  <= 1'b0;
      r_symErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_shreg  <= w_shregNext;
      r_cnt    <= w_cntNext;
      r_bValid <= w_bValidNext;
      r_bBit   <= w_bBitNext;
      r_bLast  <= w_bLastNext;
      r_symErr <= w_symErrNext;
    end
  end

  assign b_valid = r_bValid;
  assign b_bit   = r_bBit;
  assign b_last  = r_bLast;
  assign sym_err = r_symErr;

endmodule
